// File: rtl/idli_pkg.sv
// idli_pkg: shared types and SQI protocol constants for the 25LC512 quad-I/O controller.
package idli_pkg;

  typedef logic [3:0] slice_t;

  typedef enum logic [7:0] {
    SQI_READ  = 8'h03,
    SQI_WRITE = 8'h02
  } sqi_instr_t;

  typedef enum logic [2:0] {
    SQI_INIT,
    SQI_IDLE,
    SQI_INSTR,
    SQI_ADDR,
    SQI_DUMMY,
    SQI_DATA,
    SQI_GAP
  } sqi_ctrl_state_t;

  localparam int SQI_INSTR_SLOTS = 2;
  localparam int SQI_ADDR_SLOTS  = 4;
  localparam int SQI_DUMMY_SLOTS = 2;
  localparam int SQI_DATA_SLOTS  = 4;

  // A read stops after three DATA slots: the last nibble is already out after the third rise.
  function automatic logic [1:0] slot_last(input sqi_ctrl_state_t s, input logic wr);
    return s == SQI_INSTR ? 2'(SQI_INSTR_SLOTS - 1) :
           s == SQI_ADDR  ? 2'(SQI_ADDR_SLOTS - 1) :
           s == SQI_DUMMY ? 2'(SQI_DUMMY_SLOTS - 1) :
           s == SQI_DATA  ? 2'(SQI_DATA_SLOTS - (wr ? 1 : 2)) : 2'd0;
  endfunction

  function automatic sqi_ctrl_state_t slot_next(input sqi_ctrl_state_t s, input logic wr);
    return s == SQI_INIT  ? SQI_IDLE :
           s == SQI_INSTR ? SQI_ADDR :
           s == SQI_ADDR  ? (wr ? SQI_DATA : SQI_DUMMY) :
           s == SQI_DUMMY ? SQI_DATA :
           s == SQI_DATA  ? SQI_GAP : SQI_IDLE;
  endfunction

  function automatic slice_t nib(input logic [15:0] w, input logic [1:0] i);
    return slice_t'(w >> {~i, 2'b00});
  endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: SQI bus master turning single-word core reads/writes into 25LC512 quad transfers.
module idli_sqi_ctrl_m
  import idli_pkg::*;
(
  input  logic        i_gck,
  input  logic        i_rst_n,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_wr,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_data,
  output logic        o_rsp_vld,
  output logic [15:0] o_rsp_data,
  output logic        o_sqi_sck,
  output logic        o_sqi_cs,
  output slice_t      o_sqi_sio,
  output logic        o_sqi_sio_oe,
  input  slice_t      i_sqi_sio
);

  sqi_ctrl_state_t r_state, w_nxt_state;
  logic            r_ph, w_nxt_ph;
  logic [1:0]      r_cnt, w_nxt_cnt, w_last_cnt;
  logic            r_wr;
  logic [15:0]     r_addr, r_data;
  logic [11:0]     r_rd;
  logic [7:0]      w_instr;
  logic            w_acc, w_cap, w_done, w_oe;
  slice_t          w_sio;

  assign w_acc      = r_state == SQI_IDLE && i_req_vld;
  assign w_last_cnt = slot_last(r_state, r_wr);
  assign w_instr    = r_wr ? SQI_WRITE : SQI_READ;
  assign w_cap      = r_ph && ((r_state == SQI_DUMMY && r_cnt == 2'd1) || (r_state == SQI_DATA && !r_wr));
  assign w_done     = r_state == SQI_DATA && w_nxt_state == SQI_GAP;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ph    = 1'b0;
    w_nxt_cnt   = r_cnt;
    if (r_state == SQI_IDLE) w_nxt_state = w_acc ? SQI_INSTR : SQI_IDLE;
    else if (!r_ph) w_nxt_ph = 1'b1;
    else if (r_cnt != w_last_cnt) w_nxt_cnt = r_cnt + 2'd1;
    else begin
      w_nxt_cnt   = 2'd0;
      w_nxt_state = slot_next(r_state, r_wr);
    end
  end

  // Pin values are decoded from the next slot so that they are registered alongside the state.
  always_comb begin
    w_oe  = w_nxt_state == SQI_INSTR || w_nxt_state == SQI_ADDR || (w_nxt_state == SQI_DATA && r_wr);
    w_sio = w_nxt_state == SQI_INSTR ? (w_nxt_cnt[0] ? w_instr[3:0] : w_instr[7:4]) :
            w_nxt_state == SQI_ADDR  ? nib(r_addr, w_nxt_cnt) :
            w_oe                     ? nib(r_data, w_nxt_cnt) : 4'h0;
  end

  always_ff @(posedge i_gck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= SQI_INIT;
      r_ph         <= 1'b0;
      r_cnt        <= 2'd0;
      r_wr         <= 1'b0;
      r_addr       <= 16'h0;
      r_data       <= 16'h0;
      r_rd         <= 12'h0;
      o_req_rdy    <= 1'b0;
      o_rsp_vld    <= 1'b0;
      o_rsp_data   <= 16'h0;
      o_sqi_sck    <= 1'b0;
      o_sqi_cs     <= 1'b1;
      o_sqi_sio    <= 4'h0;
      o_sqi_sio_oe <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ph    <= w_nxt_ph;
      r_cnt   <= w_nxt_cnt;
      if (w_acc) begin
        r_wr   <= i_req_wr;
        r_addr <= i_req_addr;
        r_data <= i_req_data;
      end
      if (w_cap) r_rd <= {r_rd[7:0], i_sqi_sio};
      o_rsp_vld <= w_done;
      if (w_done) o_rsp_data <= r_wr ? 16'h0 : {r_rd, i_sqi_sio};
      o_req_rdy    <= w_nxt_state == SQI_IDLE;
      o_sqi_sck    <= w_nxt_ph;
      o_sqi_cs     <= w_nxt_state == SQI_INIT || w_nxt_state == SQI_GAP;
      o_sqi_sio_oe <= w_oe;
      o_sqi_sio    <= w_oe ? w_sio : 4'h0;
    end
  end

endmodule

// File: doc/idli_sqi_ctrl_m.md
# idli_sqi_ctrl_m

SQI bus master that turns single-word read/write requests from the core into serial 25LC512 SQI transactions. It sits between the core's memory request port and one SQI memory device. It generates SCK, active-high deselect CS and 4-bit SIO, and returns read data as a 16-bit word.

## Interface
- No parameters. Device protocol constants come from `idli_pkg`.
- `i_gck` in 1: core clock. All state changes on its rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req_vld` in 1: request valid.
- `o_req_rdy` out 1: request accepted when `i_req_vld && o_req_rdy` at a rising `i_gck`.
- `i_req_wr` in 1: 1 = WRITE, 0 = READ.
- `i_req_addr` in 16: byte address of the word's high byte.
- `i_req_data` in 16: write data. Bits [15:8] go to `addr`, bits [7:0] go to `addr+1`.
- `o_rsp_vld` out 1: one-cycle completion pulse, for both reads and writes.
- `o_rsp_data` out 16: read data, valid with `o_rsp_vld`. Zero for writes.
- `o_sqi_sck` out 1: SQI clock, registered.
- `o_sqi_cs` out 1: chip select. High = deselected, which resets the device FSM on the next SCK rise.
- `o_sqi_sio` out slice_t: SIO data out.
- `o_sqi_sio_oe` out 1: SIO output enable.
- `i_sqi_sio` in slice_t: SIO data from the device.

## Operation
- Every transfer is a sequence of SQI slots. Each slot is two `i_gck` cycles:
  - phase 0: SCK = 0; the controller changes SIO.
  - phase 1: SCK = 1; the device samples on the SCK rise.
- FSM states:
  - INIT, GAP: 1 slot each, CS high.
  - IDLE.
  - INSTR: 2 slots.
  - ADDR: 4 slots.
  - DUMMY: 2 slots, reads only.
  - DATA: 4 slots.
- A 2-bit nibble counter and a phase bit sequence the slots.
- Slot contents are sent MSB nibble first:
  - INSTR: 0x0, then 0x3 for READ or 0x2 for WRITE.
  - ADDR: `addr[15:12]` down to `addr[3:0]`.
  - DATA (write): `data[15:12]` down to `data[3:0]`.
- `o_sqi_sio_oe` is 1 in INSTR, ADDR and write DATA. It is 0 in DUMMY, read DATA, IDLE, INIT and GAP.
- `o_sqi_sio` is 0 whenever OE is 0.
- Read capture: the device presents data nibble k after its SCK rise in slot 7+k, counting slots 0..10 (INSTR = 0–1, ADDR = 2–5, DUMMY = 6–7, DATA = 8–10).
  - The controller samples `i_sqi_sio` on the `i_gck` edge that ends phase 1 of slots 7, 8, 9 and 10.
  - Samples shift into `o_rsp_data` MSB first.
  - A read is therefore 11 slots; the fourth DATA slot is not clocked.
- Write: 10 slots (INSTR, ADDR, DATA 4).
- After the last slot the FSM enters GAP: CS high for one full slot, including one SCK pulse, so the device returns to its instruction state. It then goes to IDLE.
- Address wrap is done by the device: a word at 0xFFFF spans 0xFFFF and 0x0000. The controller does no arithmetic on the address.

## Timing
- Reset values: `o_sqi_cs` = 1; `o_sqi_sck`, `o_sqi_sio`, `o_sqi_sio_oe`, `o_req_rdy`, `o_rsp_vld`, `o_rsp_data` = 0.
- On reset release the FSM enters INIT. INIT is one slot with CS high and one SCK pulse, which puts the device FSM in a known state. The FSM then enters IDLE.
- `o_req_rdy` = 1 only in IDLE. Requests are captured into internal registers at the accept edge A.
- Cycle A+1: CS falls, slot 0 phase 0 begins.
- Write:
  - Slots end at A+20.
  - `o_rsp_vld` = 1 at A+21, the first GAP cycle.
  - `o_req_rdy` = 1 again at A+23.
- Read:
  - `o_rsp_vld` = 1 at A+23.
  - `o_req_rdy` = 1 at A+25.
- Back-to-back: a request accepted on the first IDLE cycle starts immediately. No extra bubbles.
- `o_rsp_data` holds its value until the next response.
- Reset asserted mid-transaction: all outputs go to reset values immediately (async). The transaction is dropped, with no response. INIT follows reset release.
- `i_req_*` are ignored outside IDLE.

## Structure
- Add to `idli_pkg`:
  - `sqi_instr_t` with READ = 8'h03 and WRITE = 8'h02.
  - `sqi_ctrl_state_t` for the FSM states.
  - Slot-count constants: INSTR = 2, ADDR = 4, DUMMY = 2, DATA = 4.
- Single module, no sub-module. Shifting and phase logic are small enough to keep inline.

## Test plan
- Reset release:
  - Required: CS = 1 and one SCK pulse in the INIT slot, then `o_req_rdy` = 1 at the third `i_gck` edge after reset release.
- Write 0x1234 to 0x00A5:
  - Required: SIO at the SCK rises = 0, 2, 0, 0, A, 5, 1, 2, 3, 4.
  - Required: model bytes 0xA5 = 0x12 and 0xA6 = 0x34; `o_rsp_vld` at A+21.
- Read 0x00A5 after the write above:
  - Required: OE = 0 from slot 6 on; `o_rsp_vld` at A+23 with `o_rsp_data` = 0x1234.
- Write 0xBEEF to 0xFFFF, then read 0xFFFF:
  - Required: model 0xFFFF = 0xBE and 0x0000 = 0xEF; read returns 0xBEEF.
- Back-to-back: `i_req_vld` held high for a write followed by a read:
  - Required: the second request is accepted at A+23, and CS is high for exactly 2 cycles between the transfers.
- Reset asserted in ADDR slot 3:
  - Required: CS = 1 and SCK = 0 immediately; no `o_rsp_vld`.
  - Required: the next read after INIT returns the correct data.
